// File: rtl/aes_roundtrip_sequencer.sv
// rtl/aes_roundtrip_sequencer.sv - iterative AES-128/192/256 encrypt, decrypt and roundtrip sequencer
// Ports: clk/reset (async, active-high); start/mode/op request an operation from IDLE;
//        step_en/step gate round advance; data_in block input; round_keys expanded schedule
//        (rk[0] in the MS 128 bits); busy/done/err/match status; data_out working state;
//        ct_out ciphertext from the encrypt phase; round current round index.
module aes_roundtrip_sequencer #(
    parameter int MAX_NR = 14,
    parameter int RW     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [1:0]                op,
    input  logic                      step_en,
    input  logic                      step,
    input  logic [127:0]              data_in,
    input  logic [(MAX_NR+1)*128-1:0] round_keys,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      match,
    output logic [127:0]              data_out,
    output logic [127:0]              ct_out,
    output logic [RW-1:0]             round
);

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_DLD, S_DEC, S_FIN} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a240 = a15;
        for (int i = 0; i < 4; i++) a240 = gmul(a240, a240);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // State byte k lives at bits [127-8k -: 8]; byte k = row (k%4), column (k/4).
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? inv_sbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    // Both mix matrices are circulant: entry (row, j) is coef[(j - row) mod 4].
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        o = '0;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127-8*(j+4*c) -: 8], coef[(j - r + 4) % 4]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        end
        return o;
    endfunction

    state_t          state_q, state_d;
    logic [RW-1:0]   nr_q, nr_d, round_q, round_d;
    logic [1:0]      op_q, op_d;
    logic [127:0]    pt_q, pt_d, data_q, data_d, ct_q, ct_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d, match_q, match_d;

    logic [RW-1:0]   nr_mode, key_idx;
    int              key_sel;
    logic            adv;
    logic [127:0]    rk_cur, enc_sr, enc_mc, dec_ark, dec_mix;

    always_comb begin
        case (mode)
            2'd1:    nr_mode = RW'(12);
            2'd2:    nr_mode = RW'(14);
            default: nr_mode = RW'(10);
        endcase
        adv = step_en ? step : 1'b1;
        // The schedule is not copied; the key for the current step is picked straight off the bus.
        case (state_q)
            S_IDLE:  key_idx = (op == 2'd1) ? nr_mode : '0;
            S_DLD:   key_idx = nr_q;
            default: key_idx = round_q;
        endcase
        key_sel = (int'(key_idx) > MAX_NR) ? 0 : int'(key_idx);
        rk_cur  = round_keys[(MAX_NR - key_sel)*128 +: 128];
        enc_sr  = shift_rows(sub_bytes(data_q, 1'b0), 1'b0);
        enc_mc  = mix_columns(enc_sr, 1'b0);
        dec_ark = sub_bytes(shift_rows(data_q, 1'b1), 1'b1) ^ rk_cur;
        dec_mix = mix_columns(dec_ark, 1'b1);
    end

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        op_d    = op_q;
        pt_d    = pt_q;
        data_d  = data_q;
        ct_d    = ct_q;
        round_d = round_q;
        busy_d  = busy_q;
        match_d = match_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                if (mode == 2'd3 || op == 2'd3) begin
                    err_d = 1'b1;
                end else begin
                    pt_d    = data_in;
                    busy_d  = 1'b1;
                    match_d = 1'b0;
                    nr_d    = nr_mode;
                    op_d    = op;
                    data_d  = data_in ^ rk_cur;
                    if (op == 2'd1) begin
                        round_d = nr_mode - RW'(1);
                        state_d = S_DEC;
                    end else begin
                        round_d = RW'(1);
                        state_d = S_ENC;
                    end
                end
            end
            S_ENC: if (adv) begin
                if (round_q < nr_q) begin
                    data_d  = enc_mc ^ rk_cur;
                    round_d = round_q + RW'(1);
                end else begin
                    data_d  = enc_sr ^ rk_cur;
                    ct_d    = enc_sr ^ rk_cur;
                    state_d = (op_q == 2'd2) ? S_DLD : S_FIN;
                end
            end
            S_DLD: if (adv) begin
                data_d  = ct_q ^ rk_cur;
                round_d = nr_q - RW'(1);
                state_d = S_DEC;
            end
            S_DEC: if (adv) begin
                if (round_q != '0) begin
                    data_d  = dec_mix;
                    round_d = round_q - RW'(1);
                end else begin
                    data_d  = dec_ark;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                match_d = (op_q == 2'd2) && (data_q == pt_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            nr_q    <= '0;
            op_q    <= '0;
            pt_q    <= '0;
            data_q  <= '0;
            ct_q    <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            op_q    <= op_d;
            pt_q    <= pt_d;
            data_q  <= data_d;
            ct_q    <= ct_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            match_q <= match_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign match    = match_q;
    assign data_out = data_q;
    assign ct_out   = ct_q;
    assign round    = round_q;

endmodule

// File: tb/tb_aes_roundtrip_sequencer.sv
// tb/tb_aes_roundtrip_sequencer.sv - self-checking bench for aes_roundtrip_sequencer
module tb_aes_roundtrip_sequencer;
    localparam int MAX_NR = 14;
    localparam int RW     = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [1:0]                mode;
    logic [1:0]                op;
    logic                      step_en;
    logic                      step;
    logic [127:0]              data_in;
    logic [(MAX_NR+1)*128-1:0] round_keys;
    logic                      busy, done, err, match;
    logic [127:0]              data_out, ct_out;
    logic [RW-1:0]             round;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_roundtrip_sequencer #(.MAX_NR(MAX_NR), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .op(op),
        .step_en(step_en), .step(step), .data_in(data_in), .round_keys(round_keys),
        .busy(busy), .done(done), .err(err), .match(match),
        .data_out(data_out), .ct_out(ct_out), .round(round)
    );

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];
    logic [7:0] sb    [256];
    logic [7:0] isb   [256];
    int fwd [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    int inv [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};

    typedef struct {
        logic [1:0]   mode;
        logic [1:0]   op;
        logic [255:0] key;
        logic         corrupt;
        logic [127:0] din;
        logic [127:0] exp_out;
        logic [127:0] exp_ct;
        logic         chk_ct;
        logic         exp_match;
        logic         exp_ne_pt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Log/antilog tables over generator 3, S-box from inverse + affine map.
    task automatic build_tables();
        logic [7:0] p, x, y;
        logic [7:0] c;
        p = 8'h01;
        c = 8'h63;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = p;
            log_t[p] = 8'(i);
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        for (int a = 0; a < 256; a++) begin
            x = (a == 0) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
            for (int i = 0; i < 8; i++)
                y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
            sb[a]   = y;
            isb[y]  = 8'(a);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] bus;
        int            nr;
        nr  = nk + 6;
        rc  = 8'h01;
        bus = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) bus[(14-r)*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return bus;
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [1919:0] bus, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, o;
        k = bus[14*128 +: 128];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) begin
                    t[w+4*c] = 8'h00;
                    for (int j = 0; j < 4; j++) t[w+4*c] ^= gm(s[j+4*c], 8'(fwd[w][j]));
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            k = bus[(14-r)*128 +: 128];
            for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [1919:0] bus, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, o;
        k = bus[(14-nr)*128 +: 128];
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c-w+4)%4)];
            k = bus[(14-r)*128 +: 128];
            for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ k[127-8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) begin
                    t[w+4*c] = 8'h00;
                    for (int j = 0; j < 4; j++) t[w+4*c] ^= gm(s[j+4*c], 8'(inv[w][j]));
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [1919:0] bus_of(input vec_t v);
        logic [1919:0] bus;
        bus = expand(v.key, 4 + 2*int'(v.mode));
        if (v.corrupt) bus[9*128] = ~bus[9*128];
        return bus;
    endfunction

    function automatic vec_t fill_model(input vec_t v);
        vec_t          r;
        logic [1919:0] bus;
        int            nr;
        r   = v;
        bus = bus_of(v);
        nr  = 10 + 2*int'(v.mode);
        r.exp_match = 1'b0;
        r.exp_ne_pt = 1'b0;
        r.chk_ct    = (v.op != 2'd1);
        case (v.op)
            2'd0: begin r.exp_out = m_encrypt(v.din, bus, nr); r.exp_ct = r.exp_out; end
            2'd1: begin r.exp_out = m_decrypt(v.din, bus, nr); r.exp_ct = '0; end
            default: begin r.exp_ct = m_encrypt(v.din, bus, nr); r.exp_out = v.din; r.exp_match = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int inject, input int sp);
        logic [1919:0] bus;
        int            nr, edges;
        logic [RW-1:0] exp_round;
        logic          stepped;
        nr      = 10 + 2*int'(v.mode);
        bus     = bus_of(v);
        step_en = (sp != 0);
        step    = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mode = v.mode; op = v.op; data_in = v.din; round_keys = bus;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_start", 128'(busy), 128'(1));
        edges     = 0;
        exp_round = (v.op == 2'd1) ? RW'(nr - 1) : RW'(1);
        while (!done && edges < 400) begin
            stepped = (sp != 0) ? ((edges % sp) == sp - 1) : 1'b1;
            step    = stepped;
            if (edges == inject) begin
                start = 1'b1; mode = 2'd1; op = 2'd1; data_in = ~v.din;
            end
            @(posedge clk); #1;
            start = 1'b0;
            step  = 1'b0;
            edges++;
            if (sp != 0 && !done) begin
                if (stepped && exp_round < nr) exp_round++;
                check("step_round", 128'(round), 128'(exp_round));
            end
        end
        check("done_seen", 128'(done), 128'(1));
        if (sp == 0 && v.op != 2'd2) check("latency", 128'(edges), 128'(nr + 1));
        if (sp == 0 && v.op == 2'd2) begin
            checks++;
            if (edges < 2*nr + 2 || edges > 2*nr + 3) begin
                errors++;
                $display("FAIL rt_latency actual=%0d required=%0d..%0d", edges, 2*nr + 2, 2*nr + 3);
            end
        end
        check("data_out", data_out, v.exp_out);
        if (v.chk_ct) check("ct_out", ct_out, v.exp_ct);
        check("match", 128'(match), 128'(v.exp_match));
        if (v.exp_ne_pt) begin
            checks++;
            if (data_out == PT) begin
                errors++;
                $display("FAIL corrupt_key actual=%h required=not %h", data_out, PT);
            end
        end
        @(posedge clk); #1;
        check("done_pulse", 128'(done), 128'(0));
        check("busy_idle", 128'(busy), 128'(0));
        check("data_hold", data_out, v.exp_out);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        logic saw_done;
        vec_t v;

        build_tables();
        vecs[0] = '{2'd0, 2'd0, K128, 1'b0, PT, CT128, CT128, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 2'd0, K192, 1'b0, PT, CT192, CT192, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 2'd0, K256, 1'b0, PT, CT256, CT256, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'd2, 2'd2, K256, 1'b0, PT, PT, CT256, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'd0, 2'd1, K128, 1'b0, CT128, PT, '0, 1'b0, 1'b0, 1'b0};
        vecs[5] = fill_model('{2'd0, 2'd1, K128, 1'b1, CT128, '0, '0, 1'b0, 1'b0, 1'b0});
        vecs[5].exp_ne_pt = 1'b1;
        for (int i = 6; i < 12; i++) begin
            v.mode    = 2'($urandom_range(0, 2));
            v.op      = 2'($urandom_range(0, 2));
            v.key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v.corrupt = 1'b0;
            v.din     = {$urandom, $urandom, $urandom, $urandom};
            vecs[i]   = fill_model(v);
        end

        reset = 1'b1; start = 1'b0; mode = '0; op = '0; step_en = 1'b0; step = 1'b0;
        data_in = '0; round_keys = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_match", 128'(match), 128'(0));
        check("rst_data", data_out, 128'(0));
        check("rst_ct", ct_out, 128'(0));
        check("rst_round", 128'(round), 128'(0));
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], -1, 0);

        run_vec(vecs[0], 3, 0);
        run_vec(vecs[0], -1, 3);

        step_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd3; op = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_mode_err", 128'(err), 128'(1));
        check("illegal_mode_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check("err_pulse", 128'(err), 128'(0));
        start = 1'b1; mode = 2'd0; op = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_op_err", 128'(err), 128'(1));
        check("illegal_op_busy", 128'(busy), 128'(0));
        check("illegal_hold", data_out, CT128);

        @(posedge clk); #1;
        start = 1'b1; mode = 2'd2; op = 2'd2; data_in = PT; round_keys = expand(K256, 8);
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!(edges >= 16 && round == RW'(5)) && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check("reach_dec5", 128'(round), 128'(5));
        reset = 1'b1;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_match", 128'(match), 128'(0));
        check("arst_data", data_out, 128'(0));
        check("arst_ct", ct_out, 128'(0));
        check("arst_round", 128'(round), 128'(0));
        @(posedge clk); #1;
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_reset", 128'(saw_done), 128'(0));
        run_vec(vecs[0], -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
